put_sequencer: RTL

- Issuing side of the accumulator put interface: serializes up to three 8-bit operands (r0, r1, r2 order) into one-cycle put beats (put_flag/put_value).
- Waits for the accumulator's done acknowledge, then reports completion to the requester.
- Sits between a macro-op/test-driver source and the accumulator, where control normally drives put_flag from mach_code.

---
 rtl/put_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/put_sequencer.sv
// put_sequencer: issuing side of the accumulator put interface. Latches up to
// three operands on a request, emits them as one-cycle put beats (r0, r1, r2
// order), then waits for the accumulator's done acknowledge. The outcome is
// reported as a one-cycle done or err pulse.
module put_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] count,
    input  logic [7:0] op0,
    input  logic [7:0] op1,
    input  logic [7:0] op2,
    input  logic       hold,
    input  logic       acc_done,
    output logic       busy,
    output logic       put_flag,
    output logic [7:0] put_value,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {Idle, Issue, WaitAck} stateT;

    stateT         stateQ, stateD;
    logic [1:0]    idxQ, idxD;
    logic [1:0]    cntQ, cntD;
    logic [7:0]    op0Q, op0D;
    logic [7:0]    op1Q, op1D;
    logic [7:0]    op2Q, op2D;
    logic [CW-1:0] timerQ, timerD;
    logic          putFlagQ, putFlagD;
    logic [7:0]    putValueQ, putValueD;
    logic          doneQ, doneD;
    logic          errQ, errD;
    logic [7:0]    curOp;

    // State register; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ    <= Idle;
            idxQ      <= 2'd0;
            cntQ      <= 2'd0;
            op0Q      <= 8'd0;
            op1Q      <= 8'd0;
            op2Q      <= 8'd0;
            timerQ    <= '0;
            putFlagQ  <= 1'b0;
            putValueQ <= 8'd0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            stateQ    <= stateD;
            idxQ      <= idxD;
            cntQ      <= cntD;
            op0Q      <= op0D;
            op1Q      <= op1D;
            op2Q      <= op2D;
            timerQ    <= timerD;
            putFlagQ  <= putFlagD;
            putValueQ <= putValueD;
            doneQ     <= doneD;
            errQ      <= errD;
        end
    end

    // Next-state logic: request latch, beat issue, acknowledge wait and timeout.
    always_comb begin
        stateD    = stateQ;
        idxD      = idxQ;
        cntD      = cntQ;
        op0D      = op0Q;
        op1D      = op1Q;
        op2D      = op2Q;
        timerD    = timerQ;
        putFlagD  = 1'b0;
        putValueD = 8'd0;
        doneD     = 1'b0;
        errD      = 1'b0;

        case (idxQ)
            2'd0:    curOp = op0Q;
            2'd1:    curOp = op1Q;
            default: curOp = op2Q;
        endcase

        case (stateQ)
            Idle: begin
                if (start) begin
                    if (count == 2'd0) begin
                        errD = 1'b1;
                    end else begin
                        op0D   = op0;
                        op1D   = op1;
                        op2D   = op2;
                        cntD   = count;
                        idxD   = 2'd0;
                        stateD = Issue;
                    end
                end
            end
            Issue: begin
                if (!hold) begin
                    putFlagD  = 1'b1;
                    putValueD = curOp;
                    idxD      = idxQ + 2'd1;
                    if (idxQ == cntQ - 2'd1) begin
                        stateD = WaitAck;
                        timerD = '0;
                    end
                end
                // An acknowledge before all beats are out aborts the request;
                // a beat issued this same cycle still goes out.
                if (acc_done) begin
                    errD   = 1'b1;
                    idxD   = 2'd0;
                    stateD = Idle;
                end
            end
            WaitAck: begin
                if (acc_done) begin
                    doneD  = 1'b1;
                    stateD = Idle;
                end else if (timerQ == CW'(TIMEOUT - 1)) begin
                    errD   = 1'b1;
                    stateD = Idle;
                end else begin
                    timerD = timerQ + CW'(1);
                end
            end
            default: stateD = Idle;
        endcase
    end

    assign busy      = (stateQ != Idle);
    assign put_flag  = putFlagQ;
    assign put_value = putValueQ;
    assign done      = doneQ;
    assign err       = errQ;

endmodule
